// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a two-entry skid buffer.
// The decode is purely combinational off in_inst. The result is captured into
// the main output register, or into the skid register when the consumer stalls.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t dec, main_q, skid_q;
  state_t state;

  logic [6:0] op;
  logic       shift;
  logic signed [11:0] imm_i, imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  assign op    = in_inst[6:0];
  // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount
  assign shift = (in_inst[13:12] == 2'b01);
  assign imm_i = in_inst[31:20];
  assign imm_s = {in_inst[31:25], in_inst[11:7]};
  assign imm_b = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};

  // Decode the incoming instruction into a buffer entry; signed casts sign-extend to XLEN
  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    case (op)
      OP_IMM: begin
        if (shift) begin
          dec.typ = T_SHAMT;
          dec.imm = RV64 ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
        end else begin
          dec.typ = T_I;
          dec.imm = XLEN'(imm_i);
        end
      end
      OP_IMM32: begin
        if (!RV64) begin
          dec.ill = 1'b1;
        end else if (shift) begin
          dec.typ = T_SHAMT;
          dec.imm = XLEN'(in_inst[24:20]);
        end else begin
          dec.typ = T_I;
          dec.imm = XLEN'(imm_i);
        end
      end
      OP_LOAD, OP_JALR: begin
        dec.typ = T_I;
        dec.imm = XLEN'(imm_i);
      end
      OP_STORE: begin
        dec.typ = T_S;
        dec.imm = XLEN'(imm_s);
      end
      OP_BRANCH: begin
        dec.typ = T_B;
        dec.imm = XLEN'(imm_b);
      end
      OP_JAL: begin
        dec.typ = T_J;
        dec.imm = XLEN'(imm_j);
      end
      OP_LUI, OP_AUIPC: begin
        dec.typ = T_U;
        dec.imm = XLEN'(imm_u);
      end
      OP_OP, OP_SYSTEM, OP_MISC: dec.typ = T_NONE;
      OP_OP32: dec.ill = !RV64;
      default: dec.ill = 1'b1;
    endcase
  end

  logic accept, pop;
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Skid-buffer FSM; in_ready/out_valid are registered and follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready  <= (state != FULL);
      out_valid <= (state != EMPTY);
      case (state)
        EMPTY: if (accept) begin
          main_q    <= dec;
          state     <= ONE;
          out_valid <= 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q   <= dec;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: if (pop) begin
          main_q   <= skid_q;
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_imm     = main_q.imm;
  assign out_type    = main_q.typ;
  assign out_illegal = main_q.ill;
  assign out_tag     = main_q.tag;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It accepts a 32-bit instruction plus a sideband tag over a valid/ready handshake. It produces the XLEN-wide, RISC-V-compliant immediate, an immediate-type code and an illegal-opcode flag one cycle later. A two-entry skid buffer lets it sustain one instruction per cycle under downstream back-pressure without a combinational ready path.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of opaque sideband (e.g. PC) carried alongside each instruction.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- out_imm  out  XLEN  generated immediate.
- out_type  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_illegal  out  1  opcode not in decode set.
- out_tag  out  TAG_W  sideband of the instruction on out_*.

## Operation
- Opcode decode, with all sign extension taken from Inst[31] to XLEN:
  - OP-IMM 0010011:
    - funct3 001/101 → SHAMT, zero-extended; Inst[24:20] if XLEN=32, Inst[25:20] if XLEN=64.
    - Otherwise I, sign-extended. This includes SLTIU.
  - OP-IMM-32 0011011: XLEN=64 only; same as OP-IMM with a 5-bit shamt. With XLEN=32 it is illegal.
  - LOAD 0000011, JALR 1100111 → I.
  - STORE 0100011 → S: {Inst[31:25],Inst[11:7]}.
  - BRANCH 1100011 → B: {Inst[31],Inst[7],Inst[30:25],Inst[11:8],0}. Sign-extended for every funct3, including BLTU/BGEU.
  - JAL 1101111 → J: {Inst[31],Inst[19:12],Inst[20],Inst[30:21],0}.
  - LUI 0110111, AUIPC 0010111 → U: {Inst[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
  - OP 0110011, SYSTEM 1110011, MISC-MEM 0001111 (and OP-32 0111011 when XLEN=64) → NONE, imm 0, legal.
  - Any other opcode → NONE, imm 0, out_illegal=1.
- Storage is a main output register plus one skid register (entry = imm, type, illegal, tag).
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- EMPTY + accept → ONE.
- ONE:
  - accept and pop → ONE; main reloads with the new entry.
  - accept without pop → FULL; the new entry goes to skid.
  - pop only → EMPTY.
- FULL + pop → ONE; skid moves to main. No accept is possible in FULL.
- in_ready is a register output. It depends only on state, never on out_ready.
- Ordering is strictly FIFO. No entry is dropped or duplicated.

## Timing
- Latency: an accepted input appears on out_* at the next rising edge, when the buffer is EMPTY or ONE with a simultaneous pop.
- Throughput: 1 per cycle while out_ready=1.
- After one stall cycle the skid fills. in_ready drops the following cycle.
- out_* stay stable while out_valid && !out_ready.
- Reset, asserted at any time, including mid-transfer or in FULL:
  - Immediate effect: out_valid=0, in_ready=0, out_imm=0, out_type=0, out_illegal=0, out_tag=0; both entries discarded.
  - in_ready=1 from the first clk edge after rst_n deasserts.
- Simultaneous accept and pop in ONE is legal and must not lose either entry.
- Inputs are ignored when in_valid=0. in_inst contents are don't-care for handshake timing.

## Test plan
- XLEN=32, stream with out_ready=1:
  - 0xFFF00093 (addi −1) → imm 0xFFFFFFFF, type 1.
  - 0xFE112E23 (sw −4) → 0xFFFFFFFC, type 2.
  - 0xFE00FEE3 (bgeu −4) → 0xFFFFFFFC, type 3.
  - 0x123450B7 (lui) → 0x12345000, type 4.
  - Each result arrives 1 cycle after acceptance, back-to-back.
- XLEN=64:
  - 0x800000B7 → 0xFFFFFFFF80000000, type 4.
  - 0x02109093 (slli 33) → 0x21, type 6.
  - 0x0210909B (slliw, bit 25 set) → 0x01, type 6.
- XLEN=32: 0x0000001B → out_illegal=1, imm 0, type 0.
- Back-pressure: stream 6 tagged instructions, out_ready low for 3 cycles mid-stream → in_ready falls one cycle after the stall begins, the FULL state is reached, and all 6 tags emerge in order with no loss or duplication.
- Assert rst_n low while FULL → out_valid and in_ready go to 0 immediately with no clock. After release, in_ready=1 at the first edge and the next instruction emerges correctly.
